regfile_mp: RTL and testbench

- Parametrised successor to the datapath's 32x32 two-read/one-write register file.
- Configurable width, depth and read-port count.
- Adds byte-enable writes, optional write-to-read bypass and a hardwired zero register.
- Adds a multi-cycle soft-clear sequencer, so the file can be scrubbed without asserting global reset.
- Sits between decode (addresses) and the ALU (operands); the writeback stage drives the write port.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_mp_if.sv | 32 +++
 rtl/regfile_clr_fsm.sv | 76 +++++++
 rtl/regfile_mp.sv | 79 +++++++
 tb/tb_regfile_mp.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its
// soft-clear sequencer.
package regfile_pkg;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

  // merge_be works on the widest supported word; callers widen and truncate.
  localparam int MERGE_W    = 256;
  localparam int MERGE_BE_W = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] merge_be(
    input logic [MERGE_W-1:0]    old_v,
    input logic [MERGE_W-1:0]    new_v,
    input logic [MERGE_BE_W-1:0] be
  );
    logic [MERGE_W-1:0] r;
    r = old_v;
    for (int k = 0; k < MERGE_BE_W; k++) begin
      if (be[k]) r[k*8 +: 8] = new_v[k*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write, read and clear-control bundle between decode/writeback and the
// register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
);
  localparam int ADDR_W = $clog2(DEPTH);

  // Write port has no backpressure: a write presented with rg_wrt_en is taken
  // at the next edge while idle, or dropped (wr_drop next cycle) during a clear.
  logic                       rg_wrt_en;
  logic [ADDR_W-1:0]          rg_wrt_addr;
  logic [DATA_W/8-1:0]        rg_wrt_be;
  logic [DATA_W-1:0]          rg_wrt_data;
  logic [NUM_RD*ADDR_W-1:0]   rg_rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rg_rd_data;
  logic                       clr_req;
  logic                       clr_busy;
  logic                       clr_done;
  logic                       wr_drop;

  modport master (
    output rg_wrt_en, rg_wrt_addr, rg_wrt_be, rg_wrt_data, rg_rd_addr, clr_req,
    input  rg_rd_data, clr_busy, clr_done, wr_drop
  );

  modport slave (
    input  rg_wrt_en, rg_wrt_addr, rg_wrt_be, rg_wrt_data, rg_rd_addr, clr_req,
    output rg_rd_data, clr_busy, clr_done, wr_drop
  );
endinterface

// File: rtl/regfile_clr_fsm.sv
// Soft-clear sequencer: walks every entry once, zeroing one per cycle, and
// reports writes that arrive while it is running.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  input  logic              wr_en,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_drop,
  output logic              clr_stb,
  output logic [ADDR_W-1:0] clr_addr,
  output clr_state_t        state
);

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;
  logic              last;

  assign last = (ptr_q == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLR_IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_RUN;
          ptr_d   = '0;
        end
      end
      CLR_RUN: begin
        drop_d = wr_en;
        ptr_d  = ptr_q + ADDR_W'(1);
        // Exit after the last entry; the pointer never wraps into a second pass.
        if (last) begin
          state_d = CLR_IDLE;
          ptr_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  assign clr_busy = (state_q == CLR_RUN);
  assign clr_stb  = (state_q == CLR_RUN);
  assign clr_addr = ptr_q;
  assign clr_done = done_q;
  assign wr_drop  = drop_q;
  assign state    = state_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with byte-enable writes,
// optional write bypass, hardwired zero register and soft clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_mp_if.slave  bus,
  output clr_state_t   dbg_state
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]        mem [DEPTH];
  logic                     clr_stb;
  logic [ADDR_W-1:0]        clr_addr;
  logic                     idle;
  logic                     wr_ok;
  logic                     byp_ok;
  logic [NUM_RD*DATA_W-1:0] rd_flat;

  regfile_clr_fsm #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clr (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (bus.clr_req),
    .wr_en    (bus.rg_wrt_en),
    .clr_busy (bus.clr_busy),
    .clr_done (bus.clr_done),
    .wr_drop  (bus.wr_drop),
    .clr_stb  (clr_stb),
    .clr_addr (clr_addr),
    .state    (dbg_state)
  );

  assign idle   = (dbg_state == CLR_IDLE);
  assign wr_ok  = bus.rg_wrt_en && idle &&
                  !((ZERO_REG != 0) && (bus.rg_wrt_addr == '0));
  // Gated by reset so every port reads zero while reset is held.
  assign byp_ok = (BYPASS != 0) && reset_n && wr_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_stb) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[bus.rg_wrt_addr] <= DATA_W'(merge_be(MERGE_W'(mem[bus.rg_wrt_addr]),
                                               MERGE_W'(bus.rg_wrt_data),
                                               MERGE_BE_W'(bus.rg_wrt_be)));
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    ra      = '0;
    val     = '0;
    rd_flat = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra  = bus.rg_rd_addr[p*ADDR_W +: ADDR_W];
      val = mem[ra];
      if (byp_ok && (ra == bus.rg_wrt_addr)) begin
        val = DATA_W'(merge_be(MERGE_W'(mem[ra]), MERGE_W'(bus.rg_wrt_data),
                               MERGE_BE_W'(bus.rg_wrt_be)));
      end
      if ((ZERO_REG != 0) && (ra == '0)) val = '0;
      rd_flat[p*DATA_W +: DATA_W] = val;
    end
  end

  assign bus.rg_rd_data = rd_flat;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: one bypassing and one non-bypassing register file driven
// with identical stimulus, checked against hand-computed values.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic       clk;
  logic       clk_run;
  logic       reset_n;
  clr_state_t st_b, st_n;
  int         n_vec;
  int         n_err;

  regfile_mp_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) bus_b ();
  regfile_mp_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) bus_n ();

  regfile_mp #(.BYPASS(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .dbg_state(st_b)
  );
  regfile_mp #(.BYPASS(0)) dut_n (
    .clk(clk), .reset_n(reset_n), .bus(bus_n), .dbg_state(st_n)
  );

  // Clock / reset
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic en, input logic [4:0] addr,
                          input logic [31:0] data, input logic [3:0] be);
    bus_b.rg_wrt_en = en; bus_b.rg_wrt_addr = addr;
    bus_b.rg_wrt_data = data; bus_b.rg_wrt_be = be;
    bus_n.rg_wrt_en = en; bus_n.rg_wrt_addr = addr;
    bus_n.rg_wrt_data = data; bus_n.rg_wrt_be = be;
  endtask

  task automatic drive_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus_b.rg_rd_addr = {a1, a0};
    bus_n.rg_rd_addr = {a1, a0};
    #1;
  endtask

  task automatic drive_clr(input logic req);
    bus_b.clr_req = req;
    bus_n.clr_req = req;
  endtask

  task automatic write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
    drive_wr(1'b1, addr, data, be);
    tick();
    drive_wr(1'b0, '0, '0, '0);
  endtask

  task automatic pulse_clr();
    drive_clr(1'b1);
    tick();
    drive_clr(1'b0);
  endtask

  initial begin
    int busy_cyc, done_cnt, drop_cnt;
    n_vec   = 0;
    n_err   = 0;
    clk_run = 1'b0;
    reset_n = 1'b1;
    drive_wr(1'b0, '0, '0, '0);
    drive_clr(1'b0);
    bus_b.rg_rd_addr = '0;
    bus_n.rg_rd_addr = '0;

    // Reset with the clock stopped
    #1 reset_n = 1'b0;
    drive_rd(5'd0, 5'd5);
    check("rst_p0_a0", bus_b.rg_rd_data[31:0], 32'h0);
    check("rst_p1_a5", bus_b.rg_rd_data[63:32], 32'h0);
    drive_rd(5'd31, 5'd5);
    check("rst_p0_a31", bus_b.rg_rd_data[31:0], 32'h0);
    check("rst_n_p0_a31", bus_n.rg_rd_data[31:0], 32'h0);
    check("rst_busy", {31'd0, bus_b.clr_busy}, 32'h0);
    check("rst_done", {31'd0, bus_b.clr_done}, 32'h0);
    check("rst_drop", {31'd0, bus_b.wr_drop}, 32'h0);
    #3 reset_n = 1'b1;
    clk_run = 1'b1;
    tick();

    // Byte-enable writes
    write(5'd7, 32'hDEADBEEF, 4'b1111);
    write(5'd7, 32'h00001200, 4'b0010);
    drive_rd(5'd7, 5'd7);
    check("be_r7_b", bus_b.rg_rd_data[31:0], 32'hDEAD12EF);
    check("be_r7_n", bus_n.rg_rd_data[63:32], 32'hDEAD12EF);

    // Same-cycle bypass, full word
    drive_wr(1'b1, 5'd9, 32'hA5A5A5A5, 4'b1111);
    drive_rd(5'd9, 5'd9);
    check("byp_p0", bus_b.rg_rd_data[31:0], 32'hA5A5A5A5);
    check("byp_p1", bus_b.rg_rd_data[63:32], 32'hA5A5A5A5);
    check("nobyp_p0", bus_n.rg_rd_data[31:0], 32'h0);
    check("nobyp_p1", bus_n.rg_rd_data[63:32], 32'h0);
    tick();
    drive_wr(1'b0, '0, '0, '0);
    #1;
    check("nobyp_after", bus_n.rg_rd_data[31:0], 32'hA5A5A5A5);

    // Partial bypass merges with the stored word; only the matching port bypasses
    drive_wr(1'b1, 5'd7, 32'h00000011, 4'b0001);
    drive_rd(5'd7, 5'd9);
    check("byp_merge", bus_b.rg_rd_data[31:0], 32'hDEAD1211);
    check("byp_other", bus_b.rg_rd_data[63:32], 32'hA5A5A5A5);
    check("nobyp_merge", bus_n.rg_rd_data[31:0], 32'hDEAD12EF);
    tick();
    drive_wr(1'b0, '0, '0, '0);
    #1;
    check("merge_after", bus_n.rg_rd_data[31:0], 32'hDEAD1211);

    // Zero register
    drive_wr(1'b1, 5'd0, 32'hFFFFFFFF, 4'b1111);
    drive_rd(5'd0, 5'd0);
    check("zero_pre_p0", bus_b.rg_rd_data[31:0], 32'h0);
    check("zero_pre_p1", bus_b.rg_rd_data[63:32], 32'h0);
    tick();
    drive_wr(1'b0, '0, '0, '0);
    #1;
    check("zero_post", bus_b.rg_rd_data[31:0], 32'h0);
    check("zero_post_n", bus_n.rg_rd_data[31:0], 32'h0);
    check("zero_drop", {31'd0, bus_b.wr_drop}, 32'h0);

    // Soft clear with a dropped write
    for (int i = 1; i < 32; i++) write(5'(i), 32'(i), 4'b1111);
    drive_rd(5'd31, 5'd3);
    check("load_r31", bus_b.rg_rd_data[31:0], 32'd31);
    check("load_r3", bus_b.rg_rd_data[63:32], 32'd3);
    pulse_clr();
    busy_cyc = 0; done_cnt = 0; drop_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_b.clr_busy) busy_cyc++;
      if (bus_b.clr_done) done_cnt++;
      if (bus_b.wr_drop)  drop_cnt++;
      if (i == 10) drive_wr(1'b1, 5'd3, 32'h55, 4'b1111);
      else         drive_wr(1'b0, '0, '0, '0);
      tick();
    end
    check("clr_busy_cyc", 32'(busy_cyc), 32'd32);
    check("clr_done_cnt", 32'(done_cnt), 32'd1);
    check("clr_drop_cnt", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 32; i++) begin
      drive_rd(5'(i), 5'(31 - i));
      check($sformatf("clr_r%0d", i), bus_b.rg_rd_data[31:0], 32'h0);
    end

    // Reset in the middle of a clear
    write(5'd10, 32'h1234, 4'b1111);
    write(5'd20, 32'h5678, 4'b1111);
    pulse_clr();
    repeat (4) tick();
    check("mid_busy_pre", {31'd0, bus_b.clr_busy}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_busy_rst", {31'd0, bus_b.clr_busy}, 32'h0);
    drive_rd(5'd10, 5'd20);
    check("mid_r10", bus_b.rg_rd_data[31:0], 32'h0);
    check("mid_r20", bus_b.rg_rd_data[63:32], 32'h0);
    tick();
    reset_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_b.clr_done) done_cnt++;
      tick();
    end
    check("mid_no_done", 32'(done_cnt), 32'd0);
    pulse_clr();
    busy_cyc = 0; done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_b.clr_busy) busy_cyc++;
      if (bus_b.clr_done) done_cnt++;
      tick();
    end
    check("reclr_busy_cyc", 32'(busy_cyc), 32'd32);
    check("reclr_done_cnt", 32'(done_cnt), 32'd1);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
